// File: rtl/demux4_stream.sv
// rtl/demux4_stream.sv - registered 1-to-4 valid/ready stream demultiplexer
//
// Purpose: accepts one input stream and routes each beat to one of four
//   one-entry output registers. sel_i chooses the register. Each beat is
//   held there until that channel's consumer takes it.
//   Optional feature macro: DEMUX4_PKT_LOCK_EN. When it is defined, a packet
//   is pinned to the channel selected on its first beat until last_i.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset
//   d_i      input beat data (WIDTH bits)
//   last_i   input beat is the last beat of its packet
//   valid_i  input beat valid
//   ready_o  input beat accepted when valid_i & ready_o
//   sel_i    destination channel 0..3
//   res_o    channel k data = res_o[k*WIDTH +: WIDTH]
//   last_o   per-channel last flag
//   valid_o  per-channel valid
//   ready_i  per-channel consumer ready
//   busy_o   any channel holds a beat, or a packet is locked
module demux4_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   d_i,
  input  logic               last_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [1:0]         sel_i,
  output logic [4*WIDTH-1:0] res_o,
  output logic [3:0]         last_o,
  output logic [3:0]         valid_o,
  input  logic [3:0]         ready_i,
  output logic               busy_o
);

  logic [4*WIDTH-1:0] res_q, res_d;
  logic [3:0]         last_q, last_d;
  logic [3:0]         valid_q, valid_d;
  logic [1:0]         sel_eff;
  logic               accept;
  logic               locked;

`ifdef DEMUX4_PKT_LOCK_EN
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] lock_q, lock_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // A multi-beat packet locks onto the channel chosen by its first beat.
  // A single-beat packet (last_i on the first beat) never leaves IDLE.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (accept && !last_i) begin
          state_d = LOCKED;
          lock_d  = sel_i;
        end
      end
      LOCKED: begin
        if (accept && last_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign locked  = (state_q == LOCKED);
  assign sel_eff = locked ? lock_q : sel_i;
`else
  assign locked  = 1'b0;
  assign sel_eff = sel_i;
`endif

  // A full channel can still take a beat when it drains in the same cycle.
  // This gives one beat per cycle into a single channel.
  assign ready_o = ~valid_q[sel_eff] | ready_i[sel_eff];
  assign accept  = valid_i & ready_o;

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    last_d  = last_q;
    for (int k = 0; k < 4; k++) begin
      if (valid_q[k] && ready_i[k]) begin
        valid_d[k] = 1'b0;
      end
      // The load is applied after the drain. Drain and load in the same
      // cycle therefore leave the channel valid with the new beat.
      if (accept && (sel_eff == 2'(k))) begin
        valid_d[k]                = 1'b1;
        res_d[k*WIDTH +: WIDTH]   = d_i;
        last_d[k]                 = last_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 4'b0000;
      res_q   <= '0;
      last_q  <= 4'b0000;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      last_q  <= last_d;
    end
  end

  assign res_o   = res_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;
  assign busy_o  = (|valid_q) | locked;

endmodule

// File: tb/tb_demux4_stream.sv
// tb/tb_demux4_stream.sv - scoreboard testbench for demux4_stream
module tb_demux4_stream;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [W-1:0]   d_i;
  logic           last_i;
  logic           valid_i;
  logic           ready_o;
  logic [1:0]     sel_i;
  logic [4*W-1:0] res_o;
  logic [3:0]     last_o;
  logic [3:0]     valid_o;
  logic [3:0]     ready_i;
  logic           busy_o;

  demux4_stream #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .d_i(d_i), .last_i(last_i),
    .valid_i(valid_i), .ready_o(ready_o), .sel_i(sel_i), .res_o(res_o),
    .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Expected contents of each channel: {data, last}, oldest first.
  logic [W:0] exp_q [4][$];
  bit         locked_m = 1'b0;
  logic [1:0] lock_ch  = 2'd0;
  bit         mon_en   = 1'b0;
  int         checks   = 0;
  int         errors   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: each channel presents the oldest expected beat. A beat leaves
  // the channel when its consumer is ready.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      chk("busy_o", busy_o,
          (exp_q[0].size() != 0) || (exp_q[1].size() != 0) ||
          (exp_q[2].size() != 0) || (exp_q[3].size() != 0) || locked_m);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("valid_o[%0d]", k), valid_o[k], exp_q[k].size() != 0);
        if (exp_q[k].size() != 0) begin
          chk($sformatf("data ch%0d", k), res_o[k*W +: W], exp_q[k][0][W:1]);
          chk($sformatf("last ch%0d", k), last_o[k], exp_q[k][0][0]);
          if (ready_i[k]) void'(exp_q[k].pop_front());
        end
      end
    end
  end

  // Driver: drives one cycle of stimulus and checks ready_o against the
  // channel's free space. It then records an accepted beat in the scoreboard.
  task automatic cycle(input bit v, input logic [1:0] sel, input logic [W-1:0] d,
                       input bit l, input logic [3:0] rdy, input bit rs, output bit acc);
    logic [1:0] s;
    @(negedge clk);
    rst_i = rs; valid_i = v; sel_i = sel; d_i = d; last_i = l; ready_i = rdy;
    #2;
    s = locked_m ? lock_ch : sel;
    chk("ready_o", ready_o, exp_q[s].size() == 0);
    acc = v && ready_o && !rs;
    if (rs) begin
      for (int k = 0; k < 4; k++) exp_q[k].delete();
      locked_m = 1'b0;
    end else if (acc) begin
      exp_q[s].push_back({d, l});
`ifdef DEMUX4_PKT_LOCK_EN
      if (!locked_m && !l) begin
        locked_m = 1'b1;
        lock_ch  = sel;
      end else if (locked_m && l) begin
        locked_m = 1'b0;
      end
`endif
    end
  endtask

  initial begin
    bit         acc;
    int         n_acc;
    bit         pend;
    bit         rs;
    logic [1:0] rsel;
    logic [W-1:0] rd;
    bit         rl;

    rst_i = 1'b1; valid_i = 1'b0; sel_i = 2'd0; d_i = '0; last_i = 1'b0; ready_i = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", valid_o, 4'b0000);
    chk("reset res_o", res_o, 32'h0);
    chk("reset last_o", last_o, 4'b0000);
    chk("reset busy_o", busy_o, 1'b0);
    chk("reset ready_o", ready_o, 1'b1);
    mon_en = 1'b1;

    // 1: single beat to channel 2
    cycle(1, 2, 8'hA5, 1, 4'hF, 0, acc);
    cycle(0, 0, 8'h00, 0, 4'hF, 0, acc);

    // 2: stalled channel 1 holds two beats in order
    cycle(1, 1, 8'h11, 1, 4'h0, 0, acc);
    cycle(1, 1, 8'h22, 1, 4'h0, 0, acc);
    chk("t2 stall accept", acc, 1'b0);
    cycle(1, 1, 8'h22, 1, 4'h0, 0, acc);
    cycle(1, 1, 8'h22, 1, 4'h2, 0, acc);
    chk("t2 drain+load accept", acc, 1'b1);
    cycle(0, 0, 8'h00, 0, 4'hF, 0, acc);

    // 3: ch0 stalled full, ch3 still accepts
    cycle(1, 0, 8'h44, 1, 4'h0, 0, acc);
    cycle(1, 3, 8'h33, 1, 4'h0, 0, acc);
    chk("t3 ch3 accept", acc, 1'b1);
    cycle(0, 0, 8'h00, 0, 4'h0, 0, acc);
    cycle(0, 0, 8'h00, 0, 4'hF, 0, acc);

    // 4: four back-to-back beats into ch1
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 8'h70 + 8'(i), 1, 4'hF, 0, acc);
      if (acc) n_acc++;
    end
    chk("t4 throughput", n_acc, 4);
    cycle(0, 0, 8'h00, 0, 4'hF, 0, acc);

    // 5: three-beat packet with sel_i changing after the first beat
    cycle(1, 0, 8'hC1, 0, 4'hF, 0, acc);
    cycle(1, 3, 8'hC2, 0, 4'hF, 0, acc);
    cycle(1, 3, 8'hC3, 1, 4'hF, 0, acc);
    repeat (2) cycle(0, 0, 8'h00, 0, 4'hF, 0, acc);

    // 6: reset mid-packet with ch2 full
    cycle(1, 2, 8'h55, 0, 4'h0, 0, acc);
    cycle(0, 0, 8'h00, 0, 4'h0, 1, acc);
    @(posedge clk);
    #1;
    chk("t6 res_o after reset", res_o, 32'h0);
    chk("t6 last_o after reset", last_o, 4'b0000);
    cycle(1, 1, 8'h66, 1, 4'hF, 0, acc);
    chk("t6 accept after reset", acc, 1'b1);
    cycle(0, 0, 8'h00, 0, 4'hF, 0, acc);

    // Randomized traffic. The producer holds an unaccepted beat, and a
    // reset is issued periodically.
    pend = 1'b0; rsel = 2'd0; rd = '0; rl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend) begin
        rsel = 2'($urandom_range(0, 3));
        rd   = W'($urandom);
        rl   = ($urandom_range(0, 3) == 0);
        pend = ($urandom_range(0, 3) != 0);
      end
      rs = (i % 500 == 499);
      cycle(pend && !rs, rsel, rd, rl, 4'($urandom), rs, acc);
      if (acc || rs) pend = 1'b0;
    end

    repeat (4) cycle(0, 0, 8'h00, 1, 4'hF, 0, acc);
    for (int k = 0; k < 4; k++) chk($sformatf("drained ch%0d", k), exp_q[k].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
